// File: rtl/button_encoder.sv
// Debounces 8 raw push-buttons and encodes a single clean press as a 3-bit code with a one-cycle strobe.
// Optional input synchroniser: define BUTTON_ENC_SYNC_EN to insert a 2-flop stage on btn.
module button_encoder #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_BTN-1:0]         btn,
  output logic [$clog2(N_BTN)-1:0] code,
  output logic                     code_valid,
  output logic                     multi_press_err,
  output logic                     busy
);

  localparam int CODE_W = $clog2(N_BTN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] ONE_BTN = N_BTN'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [N_BTN-1:0]   pat, pat_d;
  logic               err_q, err_d;
  logic               code_load;
  logic [CODE_W-1:0]  pat_idx;
  logic [N_BTN-1:0]   s;
  logic               s_multi;

`ifdef BUTTON_ENC_SYNC_EN
  logic [N_BTN-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = btn;
`endif

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign s_multi = |(s & (s - ONE_BTN));

  always_comb begin
    pat_idx = '0;
    for (int i = 0; i < N_BTN; i++)
      if (pat[i]) pat_idx = CODE_W'(i);
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pat_d     = pat;
    err_d     = 1'b0;
    code_load = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_multi) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RELEASE;
          end else if (s != '0) begin
            pat_d   = s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (s_multi) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = RELEASE;
          end else if (s == pat) begin
            if (cnt == LAST) begin
              code_load = 1'b1;
              cnt_d     = '0;
              state_d   = PRESSED;
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
        RELEASE: begin
          if (s != '0) begin
            cnt_d = '0;
          end else if (cnt == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      err_q <= 1'b0;
      code  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pat   <= pat_d;
      err_q <= err_d;
      // Loaded on entry to PRESSED so the code is already new while the strobe is high.
      if (code_load) code <= pat_idx;
    end
  end

  assign code_valid      = en && (state == PRESSED);
  assign multi_press_err = en && err_q;
  assign busy            = (state != IDLE);

endmodule
